// File: rtl/dram_intlv_pkg.sv
// Shared types, default geometry constants and the channel/local-address mapping
// helper for the DRAM burst interleaver.
package dram_intlv_pkg;

    localparam int unsigned DefNumChannels = 4;
    localparam int unsigned DefBeatBytes   = 64;

    localparam int unsigned MaxChanW = 8;
    localparam int unsigned MaxAddrW = 64;
    localparam int unsigned MaxLenW  = 16;
    localparam int unsigned MaxIdW   = 16;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    // Widest supported field sizes so one definition serves every parameterisation.
    typedef struct packed {
        logic [MaxChanW-1:0] chan;
        logic [MaxAddrW-1:0] addr;
        logic [MaxLenW-1:0]  len;
        logic [MaxIdW-1:0]   id;
        logic                last;
    } frag_t;

    typedef logic [MaxChanW+MaxAddrW-1:0] chan_map_t;

    // Returns {chan, localAddr}: the channel field is addr[lowBit +: chanBits]; when
    // clearChan is set that field is zeroed in the local address, otherwise addr passes through.
    function automatic chan_map_t map_addr(input logic [MaxAddrW-1:0] addr,
                                           input logic [7:0]          lowBit,
                                           input logic [7:0]          chanBits,
                                           input logic                clearChan);
        logic [MaxAddrW-1:0] mask;
        mask     = ((MaxAddrW'(1) << chanBits) - MaxAddrW'(1)) << lowBit;
        map_addr = {MaxChanW'((addr & mask) >> lowBit), clearChan ? (addr & ~mask) : addr};
    endfunction

endpackage

// File: rtl/dram_intlv_frag_calc.sv
// Combinational fragment geometry: size, target channel, local address and last flag
// of the next fragment, derived purely from the latched burst state.
module dram_intlv_frag_calc
    import dram_intlv_pkg::*;
#(
    parameter int unsigned NumChannels   = DefNumChannels,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BeatBytes     = DefBeatBytes,
    parameter int unsigned LenWidth      = 8,
    parameter int unsigned MaxIntlvLog2  = 12,
    parameter int unsigned DramPerChSize = 32'h0100_0000
) (
    input  logic [AddrWidth-1:0]                i_addr,
    input  logic [LenWidth:0]                   i_rem,
    input  logic [$clog2(MaxIntlvLog2+1)-1:0]   i_g,
    input  logic                                i_intlvEn,
    output logic [$clog2(NumChannels)-1:0]      o_chan,
    output logic [AddrWidth-1:0]                o_addr,
    output logic [LenWidth:0]                   o_fragBeats,
    output logic                                o_last
);

    localparam int unsigned ChanW     = $clog2(NumChannels);
    localparam int unsigned RemW      = LenWidth + 1;
    localparam int unsigned BeatLog2  = $clog2(BeatBytes);
    localparam int unsigned PerChLog2 = $clog2(DramPerChSize);
    localparam int unsigned CalcW     = (MaxIntlvLog2 + 1 > RemW) ? MaxIntlvLog2 + 1 : RemW;

    logic [CalcW-1:0] w_beatIdx;
    logic [CalcW-1:0] w_blockBeats;
    logic [CalcW-1:0] w_span;
    logic [CalcW-1:0] w_remExt;
    logic [CalcW-1:0] w_intlvFrag;
    logic [7:0]       w_lowBit;

    // Only the low g bits of the beat index matter, so a CalcW-wide slice is enough.
    assign w_beatIdx    = CalcW'(i_addr >> BeatLog2);
    assign w_blockBeats = CalcW'(1) << i_g;
    assign w_span       = w_blockBeats - (w_beatIdx & (w_blockBeats - CalcW'(1)));
    assign w_remExt     = CalcW'(i_rem);
    assign w_intlvFrag  = (w_span < w_remExt) ? w_span : w_remExt;

    assign o_fragBeats = i_intlvEn ? RemW'(w_intlvFrag) : i_rem;
    assign o_last      = (o_fragBeats == i_rem);

    assign w_lowBit = i_intlvEn ? (8'(BeatLog2) + 8'(i_g)) : 8'(PerChLog2);
    assign o_addr   = AddrWidth'(map_addr(MaxAddrW'(i_addr), w_lowBit, 8'(ChanW), i_intlvEn));
    assign o_chan   = ChanW'(map_addr(MaxAddrW'(i_addr), w_lowBit, 8'(ChanW), i_intlvEn) >> MaxAddrW);

endmodule

// File: rtl/dram_burst_interleaver.sv
// Splits one INCR burst at a time into channel-contiguous fragments for the L2 DRAM channels.
// Define DRAM_INTLV_STATS_EN to build the saturating per-channel fragment counters.
module dram_burst_interleaver
    import dram_intlv_pkg::*;
#(
    parameter int unsigned NumChannels   = DefNumChannels,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned BeatBytes     = DefBeatBytes,
    parameter int unsigned LenWidth      = 8,
    parameter int unsigned IdWidth       = 6,
    parameter int unsigned MaxIntlvLog2  = 12,
    parameter int unsigned DramPerChSize = 32'h0100_0000
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               intlv_en_i,
    input  logic [$clog2(MaxIntlvLog2+1)-1:0]  intlv_log2_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [AddrWidth-1:0]               req_addr_i,
    input  logic [LenWidth-1:0]                req_len_i,
    input  logic [IdWidth-1:0]                 req_id_i,
    output logic                               out_valid_o,
    input  logic                               out_ready_i,
    output logic [$clog2(NumChannels)-1:0]     out_chan_o,
    output logic [AddrWidth-1:0]               out_addr_o,
    output logic [LenWidth-1:0]                out_len_o,
    output logic [IdWidth-1:0]                 out_id_o,
    output logic                               out_last_o,
    output logic [NumChannels*32-1:0]          stat_frag_cnt_o
);

    localparam int unsigned ChanW = $clog2(NumChannels);
    localparam int unsigned GW    = $clog2(MaxIntlvLog2 + 1);
    localparam int unsigned RemW  = LenWidth + 1;

    state_t               r_state;
    logic                 r_reqReady;
    logic                 r_outValid;
    logic [AddrWidth-1:0] r_addr;
    logic [RemW-1:0]      r_rem;
    logic [IdWidth-1:0]   r_id;
    logic                 r_intlvEn;
    logic [GW-1:0]        r_g;

    logic                 w_accept;
    logic                 w_outFire;
    logic [GW-1:0]        w_gClamped;
    logic [ChanW-1:0]     w_fragChan;
    logic [AddrWidth-1:0] w_fragAddr;
    logic [RemW-1:0]      w_fragBeats;
    logic                 w_fragLast;
    logic [AddrWidth-1:0] w_nextAddr;

    assign w_accept   = req_valid_i & r_reqReady;
    assign w_outFire  = r_outValid & out_ready_i;
    assign w_gClamped = (intlv_log2_i > GW'(MaxIntlvLog2)) ? GW'(MaxIntlvLog2) : intlv_log2_i;

    dram_intlv_frag_calc #(
        .NumChannels   (NumChannels),
        .AddrWidth     (AddrWidth),
        .BeatBytes     (BeatBytes),
        .LenWidth      (LenWidth),
        .MaxIntlvLog2  (MaxIntlvLog2),
        .DramPerChSize (DramPerChSize)
    ) u_fragCalc (
        .i_addr      (r_addr),
        .i_rem       (r_rem),
        .i_g         (r_g),
        .i_intlvEn   (r_intlvEn),
        .o_chan      (w_fragChan),
        .o_addr      (w_fragAddr),
        .o_fragBeats (w_fragBeats),
        .o_last      (w_fragLast)
    );

    // Later fragments always start beat-aligned; only the first keeps the byte offset.
    assign w_nextAddr = (r_addr & ~AddrWidth'(BeatBytes - 1)) + (AddrWidth'(w_fragBeats) << $clog2(BeatBytes));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_reqReady <= 1'b0;
            r_outValid <= 1'b0;
            r_addr     <= '0;
            r_rem      <= '0;
            r_id       <= '0;
            r_intlvEn  <= 1'b0;
            r_g        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_reqReady <= 1'b1;
                    if (w_accept) begin
                        r_addr     <= req_addr_i;
                        r_rem      <= RemW'(req_len_i) + RemW'(1);
                        r_id       <= req_id_i;
                        r_intlvEn  <= intlv_en_i;
                        r_g        <= w_gClamped;
                        r_state    <= BUSY;
                        r_reqReady <= 1'b0;
                        r_outValid <= 1'b1;
                    end
                end
                BUSY: begin
                    if (w_outFire) begin
                        if (w_fragLast) begin
                            r_state    <= IDLE;
                            r_reqReady <= 1'b1;
                            r_outValid <= 1'b0;
                        end else begin
                            r_addr <= w_nextAddr;
                            r_rem  <= r_rem - w_fragBeats;
                        end
                    end
                end
            endcase
        end
    end

    assign req_ready_o = r_reqReady;
    assign out_valid_o = r_outValid;
    assign out_chan_o  = r_outValid ? w_fragChan : '0;
    assign out_addr_o  = r_outValid ? w_fragAddr : '0;
    assign out_len_o   = r_outValid ? LenWidth'(w_fragBeats - RemW'(1)) : '0;
    assign out_id_o    = r_outValid ? r_id : '0;
    assign out_last_o  = r_outValid & w_fragLast;

`ifdef DRAM_INTLV_STATS_EN
    logic [31:0] r_fragCnt [NumChannels];

    // Saturate instead of wrapping so a long soak never reads back as light traffic.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < NumChannels; i++) begin
                r_fragCnt[i] <= '0;
            end
        end else if (w_outFire && (r_fragCnt[w_fragChan] != 32'hFFFF_FFFF)) begin
            r_fragCnt[w_fragChan] <= r_fragCnt[w_fragChan] + 32'd1;
        end
    end

    for (genvar gi = 0; gi < NumChannels; gi++) begin : g_stat
        assign stat_frag_cnt_o[gi*32 +: 32] = r_fragCnt[gi];
    end
`else
    assign stat_frag_cnt_o = '0;
`endif

endmodule

// File: tb/tb_dram_burst_interleaver.sv
// Self-checking bench for dram_burst_interleaver: directed bursts scored against a
// beat-walking fragment model, with literal pins on the model and on reset behaviour.
`timescale 1ns/1ps
module tb_dram_burst_interleaver;
    import dram_intlv_pkg::*;

    localparam longint unsigned NumCh    = 4;
    localparam longint unsigned BB       = 64;
    localparam longint unsigned PerCh    = 64'h0100_0000;
    localparam int              MaxIntlv = 12;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         intlv_en_i = 1'b1;
    logic [3:0]   intlv_log2_i = 4'd0;
    logic         req_valid_i = 1'b0;
    logic         req_ready_o;
    logic [31:0]  req_addr_i = '0;
    logic [7:0]   req_len_i = '0;
    logic [5:0]   req_id_i = '0;
    logic         out_valid_o;
    logic         out_ready_i = 1'b1;
    logic [1:0]   out_chan_o;
    logic [31:0]  out_addr_o;
    logic [7:0]   out_len_o;
    logic [5:0]   out_id_o;
    logic         out_last_o;
    logic [127:0] stat_frag_cnt_o;

    int    assertCount = 0;
    int    failCount = 0;
    frag_t modelQ[$];
    frag_t expQ[$];
    frag_t cmpExp;
`ifdef DRAM_INTLV_STATS_EN
    longint unsigned expCnt [4];
`endif

    dram_burst_interleaver dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .intlv_en_i      (intlv_en_i),
        .intlv_log2_i    (intlv_log2_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_addr_i      (req_addr_i),
        .req_len_i       (req_len_i),
        .req_id_i        (req_id_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_chan_o      (out_chan_o),
        .out_addr_o      (out_addr_o),
        .out_len_o       (out_len_o),
        .out_id_o        (out_id_o),
        .out_last_o      (out_last_o),
        .stat_frag_cnt_o (stat_frag_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input longint unsigned actual, input longint unsigned expected);
        assertCount++;
        if (actual != expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Walk the burst beat by beat; a new fragment starts whenever a beat lands in a new granule.
    function automatic void buildExpected(input longint unsigned addr, input int len, input bit en,
                                          input int lg, input int id);
        longint unsigned gran, a, granIdx, chanIdx, aligned;
        int    g;
        frag_t f;
        modelQ.delete();
        f = '0;
        f.id = 16'(id);
        if (!en) begin
            f.chan = 8'((addr / PerCh) % NumCh);
            f.addr = addr;
            f.len  = 16'(len);
            f.last = 1'b1;
            modelQ.push_back(f);
            return;
        end
        g       = (lg > MaxIntlv) ? MaxIntlv : lg;
        gran    = BB << g;
        aligned = addr - (addr % BB);
        granIdx = 0;
        for (int k = 0; k <= len; k++) begin
            a = (k == 0) ? addr : ((aligned + longint'(k) * BB) & 64'hFFFF_FFFF);
            if (k == 0 || (a / gran) != granIdx) begin
                if (k != 0) modelQ.push_back(f);
                granIdx = a / gran;
                chanIdx = granIdx % NumCh;
                f.chan  = 8'(chanIdx);
                f.addr  = a - chanIdx * gran;
                f.len   = '0;
                f.last  = 1'b0;
            end else begin
                f.len = f.len + 16'd1;
            end
        end
        f.last = 1'b1;
        modelQ.push_back(f);
    endfunction

    task automatic applyStimulus(input longint unsigned addr, input int len, input bit en,
                                 input int lg, input int id);
        int n = 0;
        while (!req_ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("reqReadyWait", longint'(n >= 100), 0);
        buildExpected(addr, len, en, lg, id);
        expQ         = modelQ;
        req_addr_i   = 32'(addr);
        req_len_i    = 8'(len);
        req_id_i     = 6'(id);
        intlv_en_i   = en;
        intlv_log2_i = 4'(lg);
        req_valid_i  = 1'b1;
        @(posedge clk_i); #1;
        req_valid_i  = 1'b0;
        intlv_en_i   = ~en;
        intlv_log2_i = 4'd1;
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while ((expQ.size() != 0 || out_valid_o) && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        checkOutput("drainTimeout", longint'(n >= budget), 0);
        checkOutput("leftoverFrags", expQ.size(), 0);
    endtask

    task automatic checkStats();
        for (int c = 0; c < 4; c++) begin
`ifdef DRAM_INTLV_STATS_EN
            checkOutput("statCnt", stat_frag_cnt_o[c*32 +: 32], expCnt[c]);
`else
            checkOutput("statCntTied", stat_frag_cnt_o[c*32 +: 32], 0);
`endif
        end
    endtask

    task automatic pinModel();
        buildExpected(64'h8000_0000, 7, 1'b1, 3, 1);
        checkOutput("pinAlignedCount", modelQ.size(), 1);
        checkOutput("pinAlignedLen", modelQ[0].len, 7);
        buildExpected(64'h8000_0100, 7, 1'b1, 3, 2);
        checkOutput("pinCrossCount", modelQ.size(), 2);
        checkOutput("pinCross0Addr", modelQ[0].addr, 64'h8000_0100);
        checkOutput("pinCross0Len", modelQ[0].len, 3);
        checkOutput("pinCross1Chan", modelQ[1].chan, 1);
        checkOutput("pinCross1Addr", modelQ[1].addr, 64'h8000_0000);
        checkOutput("pinCross1Last", modelQ[1].last, 1);
        buildExpected(64'h8000_0000, 255, 1'b1, 0, 3);
        checkOutput("pinFineCount", modelQ.size(), 256);
        checkOutput("pinFine5Chan", modelQ[5].chan, 1);
        checkOutput("pinFine3Addr", modelQ[3].addr, 64'h8000_0000);
        checkOutput("pinFine254Last", modelQ[254].last, 0);
        buildExpected(64'h8300_0040, 255, 1'b0, 3, 4);
        checkOutput("pinBypassChan", modelQ[0].chan, 3);
        checkOutput("pinBypassLen", modelQ[0].len, 255);
        buildExpected(64'h8003_FFC0, 3, 1'b1, 15, 5);
        checkOutput("pinClampCount", modelQ.size(), 2);
        checkOutput("pinClamp1Addr", modelQ[1].addr, 64'h8000_0000);
        checkOutput("pinClamp1Len", modelQ[1].len, 2);
    endtask

    // Every valid cycle is scored against the head of the expected queue; it pops on handshake.
    always @(negedge clk_i) begin
        if (rst_ni && out_valid_o) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedFrag", 1, 0);
            end else begin
                cmpExp = expQ[0];
                checkOutput("outChan", out_chan_o, cmpExp.chan);
                checkOutput("outAddr", out_addr_o, cmpExp.addr);
                checkOutput("outLen", out_len_o, cmpExp.len);
                checkOutput("outId", out_id_o, cmpExp.id);
                checkOutput("outLast", out_last_o, cmpExp.last);
                checkOutput("readyInBusy", req_ready_o, 0);
                if (out_ready_i) begin
                    void'(expQ.pop_front());
`ifdef DRAM_INTLV_STATS_EN
                    if (expCnt[cmpExp.chan[1:0]] < 64'hFFFF_FFFF) expCnt[cmpExp.chan[1:0]]++;
`endif
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: actual still running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
`ifdef DRAM_INTLV_STATS_EN
        for (int c = 0; c < 4; c++) expCnt[c] = 0;
`endif
        #1;
        checkOutput("rstReqReady", req_ready_o, 0);
        checkOutput("rstOutValid", out_valid_o, 0);
        checkOutput("rstOutLen", out_len_o, 0);
        checkOutput("rstOutLast", out_last_o, 0);
        checkStats();
        pinModel();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(posedge clk_i); #1;
        checkOutput("idleReqReady", req_ready_o, 1);

        applyStimulus(64'h8000_0000, 7, 1'b1, 3, 6'h11);
        waitDrain(100);
        applyStimulus(64'h8000_0100, 7, 1'b1, 3, 6'h12);
        waitDrain(100);
        applyStimulus(64'h8000_0110, 7, 1'b1, 3, 6'h13);
        waitDrain(100);
        applyStimulus(64'h8000_0000, 255, 1'b1, 0, 6'h14);
        waitDrain(1000);
        checkStats();
        applyStimulus(64'h8300_0040, 255, 1'b0, 3, 6'h15);
        waitDrain(100);
        applyStimulus(64'hFFFF_FF80, 3, 1'b1, 0, 6'h16);
        waitDrain(100);

        out_ready_i = 1'b0;
        applyStimulus(64'h8003_FFC0, 3, 1'b1, 15, 6'h17);
        repeat (5) begin
            @(posedge clk_i); #1;
        end
        checkOutput("stallValid", out_valid_o, 1);
        checkOutput("stallAddr", out_addr_o, 64'h8003_FFC0);
        checkOutput("stallLen", out_len_o, 0);
        checkOutput("stallReady", req_ready_o, 0);
        out_ready_i = 1'b1;
        waitDrain(100);
        checkStats();

        applyStimulus(64'h8000_0000, 3, 1'b1, 0, 6'h18);
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        checkOutput("midQueueDepth", expQ.size(), 2);
        rst_ni = 1'b0;
        expQ.delete();
`ifdef DRAM_INTLV_STATS_EN
        for (int c = 0; c < 4; c++) expCnt[c] = 0;
`endif
        #1;
        checkOutput("midRstValid", out_valid_o, 0);
        checkOutput("midRstReady", req_ready_o, 0);
        checkOutput("midRstAddr", out_addr_o, 0);
        checkStats();
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
        @(negedge clk_i);
        checkOutput("postRstValid", out_valid_o, 0);
        applyStimulus(64'h8000_0000, 7, 1'b1, 3, 6'h19);
        waitDrain(100);
        checkStats();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
